// File: rtl/nested_sum_pkg.sv
// Shared types and constants for the nested-loop summation engine.
// Holds the FSM state encoding and the accumulate-mode constants.
package nested_sum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic MODE_COUNT = 1'b0;
  localparam logic MODE_J     = 1'b1;

endpackage

// File: rtl/nsum_ctrl.sv
// Control FSM for nested_sum_unit: sequences accept, loop steps and drain.
// In: n_valid, abort, sum_ready, loop flags. Out: load, step, i_dec, state flags.
module nsum_ctrl
  import nested_sum_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic n_valid,
  input  logic abort,
  input  logic sum_ready,
  input  logic n_is_zero,
  input  logic j_eq_i,
  input  logic i_eq_1,
  output logic load,
  output logic step,
  output logic i_dec,
  output logic is_idle,
  output logic is_busy,
  output logic is_done
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    i_dec   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (n_valid) begin
          load    = 1'b1;
          state_d = n_is_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        // abort beats the final iteration; acc is left untouched
        if (abort) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (j_eq_i) begin
            if (i_eq_1) begin
              state_d = DONE;
            end else begin
              i_dec = 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (sum_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign is_idle = (state_q == IDLE);
  assign is_busy = (state_q == BUSY);
  assign is_done = (state_q == DONE);

endmodule

// File: rtl/nested_sum_unit.sv
// Nested-loop summation engine: i = N..1, j = 1..i, adds 1 or j per step.
// Ports: n_in/n_valid/n_ready in, sum/sum_valid/sum_ready out, mode, abort, overflow, busy.
module nested_sum_unit
  import nested_sum_pkg::*;
#(
  parameter int N_W   = 8,
  parameter int SUM_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_W-1:0]   n_in,
  input  logic             n_valid,
  output logic             n_ready,
  input  logic             mode,
  input  logic             abort,
  output logic [SUM_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             overflow,
  output logic             busy
);

  logic [N_W-1:0]   i_q;
  logic [N_W-1:0]   j_q;
  logic [SUM_W-1:0] acc_q;
  logic             ovf_q;
  logic             mode_q;

  logic load;
  logic step;
  logic i_dec;
  logic is_idle;
  logic is_busy;
  logic is_done;
  logic n_is_zero;
  logic j_eq_i;
  logic i_eq_1;

  logic [SUM_W-1:0] addend;
  logic [SUM_W:0]   add_w;

  assign n_is_zero = (n_in == '0);
  assign j_eq_i    = (j_q == i_q);
  assign i_eq_1    = (i_q == N_W'(1));

  // one extra bit so the carry feeds the sticky overflow
  assign addend = (mode_q == MODE_J) ? SUM_W'(j_q) : SUM_W'(1);
  assign add_w  = {1'b0, acc_q} + {1'b0, addend};

  nsum_ctrl u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .n_valid   (n_valid),
    .abort     (abort),
    .sum_ready (sum_ready),
    .n_is_zero (n_is_zero),
    .j_eq_i    (j_eq_i),
    .i_eq_1    (i_eq_1),
    .load      (load),
    .step      (step),
    .i_dec     (i_dec),
    .is_idle   (is_idle),
    .is_busy   (is_busy),
    .is_done   (is_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q    <= '0;
      j_q    <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      mode_q <= MODE_COUNT;
    end else if (load) begin
      i_q    <= n_in;
      j_q    <= N_W'(1);
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      mode_q <= mode;
    end else if (step) begin
      acc_q <= add_w[SUM_W-1:0];
      ovf_q <= ovf_q | add_w[SUM_W];
      if (i_dec) begin
        i_q <= i_q - N_W'(1);
        j_q <= N_W'(1);
      end else if (!j_eq_i) begin
        j_q <= j_q + N_W'(1);
      end
    end
  end

  assign n_ready   = is_idle;
  assign busy      = is_busy;
  assign sum_valid = is_done;
  assign sum       = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_nested_sum_unit.sv
// Directed scoreboard bench for nested_sum_unit (SUM_W=32 and SUM_W=16).
// Expected sums come from closed-form loop formulas.
module tb_nested_sum_unit;

  logic        clk;
  logic        reset;
  logic [7:0]  n_in;
  logic        nv32;
  logic        nv16;
  logic        mode;
  logic        abort;
  logic        sum_ready;

  logic        nr32;
  logic [31:0] s32;
  logic        sv32;
  logic        of32;
  logic        bz32;

  logic        nr16;
  logic [15:0] s16;
  logic        sv16;
  logic        of16;
  logic        bz16;

  logic        sel16;

  typedef struct {
    logic [31:0] sum;
    logic        ovf;
    int          k;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   failures;

  nested_sum_unit #(.N_W(8), .SUM_W(32)) d32 (
    .clk       (clk),
    .reset     (reset),
    .n_in      (n_in),
    .n_valid   (nv32),
    .n_ready   (nr32),
    .mode      (mode),
    .abort     (abort),
    .sum       (s32),
    .sum_valid (sv32),
    .sum_ready (sum_ready),
    .overflow  (of32),
    .busy      (bz32)
  );

  nested_sum_unit #(.N_W(8), .SUM_W(16)) d16 (
    .clk       (clk),
    .reset     (reset),
    .n_in      (n_in),
    .n_valid   (nv16),
    .n_ready   (nr16),
    .mode      (mode),
    .abort     (abort),
    .sum       (s16),
    .sum_valid (sv16),
    .sum_ready (sum_ready),
    .overflow  (of16),
    .busy      (bz16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] c_sum();
    return sel16 ? {16'd0, s16} : s32;
  endfunction
  function automatic logic c_valid();
    return sel16 ? sv16 : sv32;
  endfunction
  function automatic logic c_busy();
    return sel16 ? bz16 : bz32;
  endfunction
  function automatic logic c_nready();
    return sel16 ? nr16 : nr32;
  endfunction
  function automatic logic c_ovf();
    return sel16 ? of16 : of32;
  endfunction

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int n, input bit m,
                                 input int w);
    exp_t   e;
    longint t;
    longint n64;
    n64 = longint'(n);
    if (m) t = n64 * (n64 + 1) * (n64 + 2) / 6;
    else   t = n64 * (n64 + 1) / 2;
    e.sum = 32'(t & ((64'd1 << w) - 1));
    e.ovf = (t >= (64'd1 << w));
    e.k   = n * (n + 1) / 2;
    return e;
  endfunction

  task automatic start(input int n, input bit m);
    chk("n_ready_before_accept", longint'(c_nready()), 1);
    n_in = 8'(n);
    mode = m;
    if (sel16) nv16 = 1'b1;
    else       nv32 = 1'b1;
    @(posedge clk);
    #1;
    nv16 = 1'b0;
    nv32 = 1'b0;
    q.push_back(model(n, m, sel16 ? 16 : 32));
  endtask

  task automatic wait_result(input string tag);
    int   lat;
    int   bc;
    exp_t e;
    lat = 0;
    bc  = 0;
    while (!c_valid() && lat < 40000) begin
      if (c_busy()) bc++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!c_valid()) begin
      chk({tag, "_timeout"}, 0, 1);
    end else if (q.size() == 0) begin
      chk({tag, "_unexpected"}, 1, 0);
    end else begin
      e = q.pop_front();
      chk({tag, "_sum"}, longint'(c_sum()), longint'(e.sum));
      chk({tag, "_ovf"}, longint'(c_ovf()), longint'(e.ovf));
      chk({tag, "_latency"}, lat, e.k);
      chk({tag, "_busy_cycles"}, bc, e.k);
    end
  endtask

  initial begin
    logic [31:0] hold;
    int          seen;
    checks    = 0;
    failures  = 0;
    sel16     = 1'b0;
    reset     = 1'b1;
    n_in      = '0;
    nv32      = 1'b0;
    nv16      = 1'b0;
    mode      = 1'b0;
    abort     = 1'b0;
    sum_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_n_ready", longint'(nr32), 1);
    chk("rst_busy", longint'(bz32), 0);
    chk("rst_sum_valid", longint'(sv32), 0);
    chk("rst_sum", longint'(s32), 0);
    chk("rst_ovf", longint'(of32), 0);

    // N=4, mode=1
    start(4, 1'b1);
    wait_result("n4_m1");
    @(posedge clk);
    #1;
    chk("n4_valid_one_cycle", longint'(sv32), 0);
    chk("n4_back_idle", longint'(nr32), 1);

    // N=0 goes straight to DONE
    start(0, 1'b1);
    wait_result("n0");
    @(posedge clk);
    #1;

    // 16-bit accumulator wraps
    sel16 = 1'b1;
    start(100, 1'b1);
    wait_result("w16_n100");
    @(posedge clk);
    #1;
    chk("w16_back_idle", longint'(nr16), 1);
    sel16 = 1'b0;

    // largest operand
    start(255, 1'b1);
    wait_result("n255_m1");
    @(posedge clk);
    #1;

    // backpressure in DONE
    sum_ready = 1'b0;
    start(6, 1'b0);
    wait_result("n6_bp");
    hold = s32;
    for (int c = 0; c < 5; c++) begin
      nv32 = (c == 2);
      n_in = 8'd9;
      @(posedge clk);
      #1;
      chk("bp_valid_held", longint'(sv32), 1);
      chk("bp_sum_stable", longint'(s32), longint'(hold));
      chk("bp_n_ready_low", longint'(nr32), 0);
    end
    nv32      = 1'b0;
    sum_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_after_hs", longint'(nr32), 1);
    chk("bp_valid_dropped", longint'(sv32), 0);
    chk("bp_no_accept", longint'(bz32), 0);

    // abort on the 3rd busy cycle
    start(10, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("ab_busy_before", longint'(bz32), 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    void'(q.pop_front());
    chk("ab_idle", longint'(nr32), 1);
    chk("ab_not_busy", longint'(bz32), 0);
    seen = 0;
    repeat (4) begin
      if (sv32) seen++;
      @(posedge clk);
      #1;
    end
    chk("ab_no_valid", seen, 0);
    start(3, 1'b1);
    wait_result("after_abort_n3");
    @(posedge clk);
    #1;

    // asynchronous reset mid-BUSY
    start(20, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    void'(q.pop_front());
    chk("arst_n_ready", longint'(nr32), 1);
    chk("arst_busy", longint'(bz32), 0);
    chk("arst_sum", longint'(s32), 0);
    chk("arst_ovf", longint'(of32), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    start(2, 1'b0);
    wait_result("after_rst_n2");
    @(posedge clk);
    #1;

    chk("scoreboard_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nested_sum_unit.md
Name: nested_sum_unit

Overview:
- Self-contained nested-loop summation engine with its own control FSM and datapath.
- Accepts an operand N through a valid/ready handshake and runs an outer loop i = N down to 1, with an inner loop j = 1 up to i.
- Accumulates either the iteration count or j, then presents the result through a second valid/ready handshake.
- Compared with the earlier fixed control path, it adds width parameters, a mode input, output backpressure, abort and a sticky overflow flag.

Parameters:
- N_W, 8, width of operand N and of the i/j counters.
- SUM_W, 32, width of the accumulator and the sum output.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- n_in  in  N_W  operand N, unsigned.
- n_valid  in  1  n_in is valid.
- n_ready  out  1  block can accept N; high only in IDLE.
- mode  in  1  sampled at accept. 0 = add 1 per inner iteration; 1 = add j.
- abort  in  1  cancel the current computation.
- sum  out  SUM_W  accumulator value.
- sum_valid  out  1  sum is final; high only in DONE.
- sum_ready  in  1  consumer takes sum.
- overflow  out  1  sticky carry-out of the accumulator for the current transaction.
- busy  out  1  high in BUSY.

Behaviour:
- Reset (any time, including mid-BUSY or in DONE):
  - state = IDLE; i, j, acc = 0; overflow = 0; mode register = 0.
  - Outputs: n_ready = 1, sum_valid = 0, busy = 0, sum = 0.
- States: IDLE, BUSY, DONE. All outputs are decoded from registered state, so no combinational path runs from inputs to outputs.
- IDLE:
  - On n_valid && n_ready at edge T0, latch mode, set i = n_in, j = 1, acc = 0, overflow = 0.
  - Next state is BUSY, or DONE if n_in == 0 (sum = 0, one cycle after accept).
  - abort is ignored in IDLE.
- BUSY, each cycle:
  - acc += (mode ? zero-extended j : 1), computed on SUM_W+1 bits; overflow |= carry; acc keeps the low SUM_W bits (wraps).
  - If j == i and i == 1: this is the last iteration; next state DONE.
  - Else if j == i: i = i - 1, j = 1.
  - Else: j = j + 1.
- Latency:
  - BUSY lasts exactly K = N(N+1)/2 cycles. sum_valid rises at edge T0 + K + 1 relative to the accept edge.
  - Result is N(N+1)/2 when mode = 0, and N(N+1)(N+2)/6 when mode = 1, modulo 2^SUM_W.
- DONE:
  - sum_valid = 1. sum and overflow are held stable until sum_valid && sum_ready.
  - Next state is IDLE on the cycle after the handshake. n_valid is ignored in DONE (n_ready = 0).
- Abort:
  - In BUSY, abort = 1 moves the block to IDLE on the next edge; no sum_valid pulse is produced.
  - The accumulator is left as is and is cleared on the next accept.
  - abort in DONE is ignored; the result must be drained.
- Simultaneous events:
  - abort coinciding with the last BUSY iteration: abort wins and the block goes to IDLE.
  - reset overrides everything.
- i and j never exceed N, so they never wrap within N_W. N = 2^N_W − 1 is legal.

Decomposition:
- Shared package nested_sum_pkg holds:
  - state encoding localparams IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10;
  - mode constants MODE_COUNT = 0, MODE_J = 1.
- Sub-module nsum_ctrl: the FSM.
  - Inputs: n_valid, abort, sum_ready, n_is_zero, j_eq_i, i_eq_1.
  - Outputs: load, step, i_dec, state flags.
- The top level holds the i/j/acc/overflow datapath and instantiates nsum_ctrl.

Test Plan:
- N=4, mode=1, sum_ready=1 → 10 busy cycles; sum=20 with sum_valid at T0+11 for one cycle; overflow=0; n_ready back to 1 one cycle later.
- N=0, mode=1 → sum_valid at T0+1; sum=0; busy never asserted.
- Accumulator wrap (SUM_W=16 instance), N=100, mode=1 → sum=40628 (171700 mod 65536), overflow=1. With the default SUM_W=32, N=255, mode=1 → sum=2796160 after 32640 busy cycles.
- N=6, mode=0, sum_ready held low 5 cycles after DONE → sum=21 and sum_valid held stable; an n_valid pulse during DONE is not accepted; IDLE is reached one cycle after sum_ready rises.
- N=10, abort pulsed on the 3rd busy cycle → IDLE next cycle, sum_valid never asserts; a following N=3, mode=1 gives sum=10 and overflow=0.
- reset asserted asynchronously mid-BUSY (N=20) → immediately n_ready=1, busy=0, sum=0, overflow=0; a fresh N=2, mode=0 gives sum=3.
